// File: rtl/rom_loader.sv
// rom_loader: streams 16-bit coefficient words, packs three of them into one
// 48-bit entry and writes it into a coefficient table at a wrapping 6-bit
// index. A load covers `len` entries (0 means 64) starting at `base_addr`.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to add a 16-bit running sum
// of accepted words; without it `checksum` is tied to zero.
//
// din handshake: a word transfers on a rising clk edge exactly when
// din_valid and din_ready are both 1. din_ready is high in COLLECT and drops
// combinationally while abort is asserted, so an aborted cycle never
// consumes a word.
module rom_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  base_addr,
    input  logic [5:0]  len,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        abort,
    output logic        cen,
    output logic        wen,
    output logic [5:0]  index_wri,
    output logic [47:0] D,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic [5:0]  cnt_q, cnt_d;     // entries left; 0 encodes 64
    logic [1:0]  wcnt_q, wcnt_d;   // words already packed into this entry
    logic [31:0] pack_q, pack_d;   // first two words of the entry
    logic [47:0] data_q, data_d;   // entry presented on D

    logic start_acc;
    logic accept;

    assign start_acc   = (state_q == S_IDLE) && start;
    assign accept      = din_valid && din_ready;
    assign dbg_state_o = state_q;
    assign index_wri   = addr_q;
    assign D           = data_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; abort wins over any transfer or write
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_COLLECT;
            S_COLLECT: begin
                if (abort)                           state_d = S_IDLE;
                else if (accept && wcnt_q == 2'd2)   state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort)               state_d = S_IDLE;
                else if (cnt_q == 6'd1)  state_d = S_DONE;
                else                     state_d = S_COLLECT;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode from state, gated by abort where it must suppress effects
    always_comb begin
        din_ready = (state_q == S_COLLECT) && !abort;
        wen       = !((state_q == S_WRITE) && !abort);
        busy      = (state_q != S_IDLE);
        cen       = (state_q != S_IDLE);
        done      = (state_q == S_DONE) && !abort;
    end

    // Datapath next values: counters, word packing and the output entry
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        wcnt_d = wcnt_q;
        pack_d = pack_q;
        data_d = data_q;
        if (start_acc) begin
            addr_d = base_addr;
            cnt_d  = len;
            wcnt_d = 2'd0;
        end else if (state_q == S_COLLECT) begin
            if (abort) begin
                wcnt_d = 2'd0;
            end else if (accept) begin
                case (wcnt_q)
                    2'd0: begin
                        pack_d[31:16] = din;
                        wcnt_d        = 2'd1;
                    end
                    2'd1: begin
                        pack_d[15:0] = din;
                        wcnt_d       = 2'd2;
                    end
                    default: begin
                        data_d = {pack_q, din};
                        wcnt_d = 2'd0;
                    end
                endcase
            end
        end else if (state_q == S_WRITE && !abort) begin
            addr_d = addr_q + 6'd1;
            cnt_d  = cnt_q - 6'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
            wcnt_q <= '0;
            pack_q <= '0;
            data_q <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            wcnt_q <= wcnt_d;
            pack_q <= pack_d;
            data_q <= data_d;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Running sum: cleared by an accepted start, grows with each accepted word
    always_comb begin
        csum_d = csum_q;
        if (start_acc)   csum_d = '0;
        else if (accept) csum_d = csum_q + din;
    end

    // Checksum register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule
